// File: rtl/axis_rr_packet_arbiter_if.sv
// AXI-Stream bundle that carries LANES parallel streams of DATA_WIDTH bits.
// Lane i of tdata occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. With LANES=1
// it is an ordinary single AXI-Stream link.
interface axis_rr_packet_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter. Several sources share one sink.
// A source keeps the grant from its first beat until its tlast beat, so
// packets are never interleaved. Each new arbitration starts searching at
// the source after the previous winner. After a packet is locked, the data
// path is a pure combinational mux from the granted source.
module axis_rr_packet_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_rr_packet_arbiter_if.slave  s,
    axis_rr_packet_arbiter_if.master m,
    output logic [ID_WIDTH-1:0]  m_tid,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    localparam int                SUM_W     = ID_WIDTH + 1;
    localparam logic [SUM_W-1:0]  NUM_SRC_W = SUM_W'(NUM_SRC);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SRC - 1);

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ID_WIDTH-1:0]    grant;
    logic [ID_WIDTH-1:0]    grant_nxt;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [ID_WIDTH-1:0]    rr_ptr_nxt;
    logic [CNT_WIDTH-1:0]   count_nxt;
    logic [SUM_W-1:0]       sum;
    logic [ID_WIDTH-1:0]    cand;
    logic                   found;

    // Register the lock state, the current grant, the fairness pointer and the packet counter
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            pkt_count <= count_nxt;
        end
    end

    // Pick the next owner in IDLE; while locked, forward the owner and release on its tlast beat
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        count_nxt  = pkt_count;
        s.tready   = '0;
        m.tdata    = '0;
        m.tvalid   = 1'b0;
        m.tlast    = 1'b0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;

        case (state)
            IDLE: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    sum = {1'b0, rr_ptr} + SUM_W'(k);
                    if (sum >= NUM_SRC_W) begin
                        sum = sum - NUM_SRC_W;
                    end
                    cand = sum[ID_WIDTH-1:0];
                    if (!found && s.tvalid[cand]) begin
                        found     = 1'b1;
                        grant_nxt = cand;
                        state_nxt = PASS;
                    end
                end
            end

            PASS: begin
                m.tdata         = s.tdata[grant*DATA_WIDTH +: DATA_WIDTH];
                m.tvalid        = s.tvalid[grant];
                m.tlast         = s.tlast[grant];
                s.tready[grant] = m.tready[0];
                if (s.tvalid[grant] && m.tready[0] && s.tlast[grant]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant == LAST_ID) ? '0 : grant + ID_WIDTH'(1);
                    count_nxt  = pkt_count + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m_tid = grant;
    assign busy  = (state == PASS);

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Bench for the round-robin packet arbiter. Sources are fed from per-source
// beat queues. A reference model that knows only owner, pointer and count
// predicts each granted packet into a scoreboard queue. A separate monitor
// pops that queue on every output handshake.
module tb_axis_rr_packet_arbiter;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
        int            seq;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
        logic          first;
    } exp_t;

    logic          aclk   = 1'b0;
    logic          areset = 1'b1;
    logic [IW-1:0] m_tid;
    logic          busy;
    logic [CW-1:0] pkt_count;

    axis_rr_packet_arbiter_if #(.DATA_WIDTH(DW), .LANES(NS)) s_if ();
    axis_rr_packet_arbiter_if #(.DATA_WIDTH(DW), .LANES(1))  m_if ();

    axis_rr_packet_arbiter #(
        .DATA_WIDTH(DW), .NUM_SRC(NS), .ID_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .areset(areset), .s(s_if.slave), .m(m_if.master),
        .m_tid(m_tid), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    beat_t         src_q[NS][$];
    exp_t          exp_q[$];
    int            first_ids[$];
    int            cur_seq[NS];
    int            gap_cnt[NS];
    logic [NS-1:0] fire = '0;
    int            seq_ctr    = 0;
    int            ready_pct  = 100;
    int            stall_left = 0;
    int            checks     = 0;
    int            passes     = 0;

    logic          mdl_busy  = 1'b0;
    int            mdl_owner = 0;
    int            mdl_rr    = 0;
    int            mdl_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic int pendingBeats();
        int n = exp_q.size();
        for (int i = 0; i < NS; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic driveInputs(input bit advance);
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                if (src_q[i][0].seq != cur_seq[i]) begin
                    cur_seq[i] = src_q[i][0].seq;
                    gap_cnt[i] = src_q[i][0].gap;
                end else if (advance && gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                end
                s_if.tvalid[i]          = (gap_cnt[i] == 0);
                s_if.tlast[i]           = src_q[i][0].last;
                s_if.tdata[i*DW +: DW]  = src_q[i][0].data;
            end else begin
                s_if.tvalid[i]          = 1'b0;
                s_if.tlast[i]           = 1'b0;
                s_if.tdata[i*DW +: DW]  = '0;
            end
        end
        if (advance) begin
            if (stall_left > 0) begin
                m_if.tready = 1'b0;
                stall_left--;
            end else begin
                m_if.tready = (int'($urandom_range(0, 99)) < ready_pct) ? 1'b1 : 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge aclk);
            fire = s_if.tvalid & s_if.tready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < NS; i++)
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            driveInputs(1'b1);
        end
    endtask

    task automatic loadPacket(input int src, input int len, input int first_data,
                              input int bubble_at, input int bubble_len);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.data = (first_data >= 0) ? DW'(first_data + k) : DW'($urandom);
            b.last = (k == len - 1);
            b.gap  = (k == bubble_at) ? bubble_len : 0;
            b.seq  = seq_ctr;
            seq_ctr++;
            src_q[src].push_back(b);
        end
        driveInputs(1'b0);
    endtask

    // Called at posedge+1; asserts reset mid-cycle and drops every queued source beat.
    task automatic doReset();
        #2;
        areset = 1'b1;
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            cur_seq[i] = -1;
            gap_cnt[i] = 0;
        end
        fire = '0;
        driveInputs(1'b0);
        #1;
        checkOutput("rst_m_tvalid",  32'(m_if.tvalid), 32'd0);
        checkOutput("rst_m_tdata",   32'(m_if.tdata),  32'd0);
        checkOutput("rst_m_tlast",   32'(m_if.tlast),  32'd0);
        checkOutput("rst_busy",      32'(busy),        32'd0);
        checkOutput("rst_m_tid",     32'(m_tid),       32'd0);
        checkOutput("rst_pkt_count", 32'(pkt_count),  32'd0);
        checkOutput("rst_s_tready",  32'(s_if.tready), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        first_ids.delete();
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (pendingBeats() != 0) begin
            if (n >= budget) begin
                checkOutput({name, "_timeout_pending"}, 32'(pendingBeats()), 32'd0);
                break;
            end
            applyStimulus(1);
            n++;
        end
        applyStimulus(1);
    endtask

    task automatic checkOrder(input string name, input int exp_ids[$]);
        checkOutput({name, "_pkts"}, 32'(first_ids.size()), 32'(exp_ids.size()));
        for (int k = 0; k < exp_ids.size(); k++)
            checkOutput($sformatf("%s_grant%0d", name, k),
                        (k < first_ids.size()) ? 32'(first_ids[k]) : 32'hFFFF_FFFF, 32'(exp_ids[k]));
    endtask

    // Reference model: owner/pointer/count; predicts each granted packet into the scoreboard
    initial begin : ref_model
        forever begin
            @(negedge aclk);
            if (areset) begin
                mdl_busy  = 1'b0;
                mdl_rr    = 0;
                mdl_count = 0;
                exp_q.delete();
            end else begin
                checkOutput("busy", 32'(busy), 32'(mdl_busy));
                checkOutput("pkt_count", 32'(pkt_count), 32'(mdl_count));
                if (mdl_busy) begin
                    checkOutput("m_tid", 32'(m_tid), 32'(mdl_owner));
                    checkOutput("m_tvalid", 32'(m_if.tvalid), 32'(s_if.tvalid[mdl_owner]));
                    checkOutput("s_tready", 32'(s_if.tready),
                                m_if.tready[0] ? (32'd1 << mdl_owner) : 32'd0);
                    if (s_if.tvalid[mdl_owner] && !m_if.tready[0] && exp_q.size() > 0)
                        checkOutput("stall_tdata", 32'(m_if.tdata), 32'(exp_q[0].data));
                    if (s_if.tvalid[mdl_owner] && m_if.tready[0] && s_if.tlast[mdl_owner]) begin
                        mdl_busy  = 1'b0;
                        mdl_rr    = (mdl_owner + 1) % NS;
                        mdl_count = (mdl_count + 1) % (1 << CW);
                    end
                end else begin
                    checkOutput("idle_m_tvalid", 32'(m_if.tvalid), 32'd0);
                    checkOutput("idle_s_tready", 32'(s_if.tready), 32'd0);
                    for (int k = 0; k < NS; k++) begin
                        int idx;
                        idx = (mdl_rr + k) % NS;
                        if (!mdl_busy && s_if.tvalid[idx]) begin
                            mdl_busy  = 1'b1;
                            mdl_owner = idx;
                            for (int j = 0; j < src_q[idx].size(); j++) begin
                                exp_t e;
                                e.data  = src_q[idx][j].data;
                                e.last  = src_q[idx][j].last;
                                e.id    = IW'(idx);
                                e.first = (j == 0);
                                exp_q.push_back(e);
                                if (src_q[idx][j].last) break;
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: every output handshake must match the next predicted beat
    initial begin : monitor
        forever begin
            @(negedge aclk);
            if (!areset && m_if.tvalid[0] && m_if.tready[0]) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat_tvalid", 32'(m_if.tvalid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("beat_tdata", 32'(m_if.tdata), 32'(e.data));
                    checkOutput("beat_tlast", 32'(m_if.tlast), 32'(e.last));
                    checkOutput("beat_tid",   32'(m_tid),      32'(e.id));
                    if (e.first) first_ids.push_back(int'(m_tid));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        for (int i = 0; i < NS; i++) begin
            cur_seq[i] = -1;
            gap_cnt[i] = 0;
        end
        s_if.tdata  = '0;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        m_if.tready = 1'b1;
        #1;
        doReset();

        // Single requester: source 2, three beats; first beat visible one cycle later
        ready_pct = 100;
        loadPacket(2, 3, 'hA1, -1, 0);
        applyStimulus(1);
        checkOutput("first_beat_valid", 32'(m_if.tvalid), 32'd1);
        checkOutput("first_beat_data",  32'(m_if.tdata),  32'hA1);
        checkOutput("first_beat_tid",   32'(m_tid),       32'd2);
        waitDrain("single", 50);
        checkOutput("single_count", 32'(pkt_count), 32'd1);
        checkOrder("single", '{2});

        // Round robin: all sources valid with 2-beat packets
        doReset();
        loadPacket(0, 2, 'h10, -1, 0);
        loadPacket(0, 2, 'h18, -1, 0);
        loadPacket(1, 2, 'h20, -1, 0);
        loadPacket(2, 2, 'h30, -1, 0);
        loadPacket(3, 2, 'h40, -1, 0);
        waitDrain("rr", 100);
        checkOutput("rr_count", 32'(pkt_count), 32'd5);
        checkOrder("rr", '{0, 1, 2, 3, 0});

        // Lock: source 0 bubbles mid-packet while source 1 waits
        doReset();
        loadPacket(0, 4, 'h50, 2, 2);
        loadPacket(1, 2, 'h60, -1, 0);
        waitDrain("lock", 100);
        checkOrder("lock", '{0, 1});

        // Backpressure: three stalled cycles in the middle of a source 1 packet
        first_ids.delete();
        loadPacket(1, 5, 'h70, -1, 0);
        applyStimulus(3);
        stall_left = 3;
        applyStimulus(2);
        checkOutput("stall_m_tid",    32'(m_tid),       32'd1);
        checkOutput("stall_s_tready", 32'(s_if.tready), 32'd0);
        waitDrain("bp", 100);
        checkOutput("bp_count", 32'(pkt_count), 32'd3);
        checkOrder("bp", '{1});

        // Reset after beat 2 of 4 from source 3; arbitration restarts at source 0
        loadPacket(3, 4, 'h80, -1, 0);
        applyStimulus(3);
        doReset();
        loadPacket(3, 2, 'h90, -1, 0);
        loadPacket(0, 2, 'hA8, -1, 0);
        waitDrain("rst_mid", 100);
        checkOutput("rst_mid_count", 32'(pkt_count), 32'd2);
        checkOrder("rst_mid", '{0, 3});

        // Random traffic with bubbles and backpressure; 42 packets wrap the 4-bit counter
        ready_pct = 70;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 5));
            loadPacket(int'($urandom_range(0, NS - 1)), len, -1,
                       int'($urandom_range(0, len - 1)), int'($urandom_range(0, 2)));
        end
        waitDrain("random", 3000);
        checkOutput("random_count", 32'(pkt_count), 32'((2 + 40) % (1 << CW)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
